fetch_ctrl: RTL and testbench

//  Fetch sequencer directly upstream of the PC register. Drives its pc_bar input and fetches from an instruction memory with variable latency over a req/ack handshake.

---
 rtl/fetch_ctrl.sv | 150 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
//   Fetch sequencer sitting directly upstream of the PC register. It fetches
//   the instruction at pc from a variable-latency instruction memory (req/ack),
//   presents it to decode/execute for one or more cycles, and computes the next
//   PC (sequential, branch or jump). Any fetch timeout or misaligned target
//   parks the sequencer in a sticky error state that only reset clears.
//
// Ports
//   clk            system clock, all state on rising edge
//   reset          asynchronous, active-high
//   pc             current PC from the PC register
//   pc_bar         next PC to the PC register (combinational)
//   imem_req       fetch request, level, held until imem_ack
//   imem_addr      fetch address (= pc)
//   imem_ack       one-cycle pulse, imem_rdata valid
//   imem_rdata     instruction word from memory
//   instr          registered instruction to decode
//   instr_valid    instr valid / execute window
//   stall          downstream not ready to retire instr
//   branch_taken   redirect to branch_target (EXEC, no stall)
//   branch_target  branch destination
//   jump           redirect to jump_target, priority over branch
//   jump_target    jump destination
//   fetch_err      sticky error flag
// ----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] pc,
    output logic [N-1:0] pc_bar,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  instr,
    output logic         instr_valid,
    input  logic         stall,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    output logic         fetch_err
);

    localparam int            CW   = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_EXEC,
        S_ERR
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic [31:0]    instr_nxt;
    logic           valid_nxt;
    logic           err_nxt;
    logic [N-1:0]   target;

    // Candidate next PC; only used when leaving EXEC without a stall.
    // pc + 4 wraps naturally at the top of the address space.
    assign target    = jump         ? jump_target   :
                       branch_taken ? branch_target :
                                      pc + N'(4);

    assign imem_addr = pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_REQ;
            count       <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            instr       <= instr_nxt;
            instr_valid <= valid_nxt;
            fetch_err   <= err_nxt;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves a signal unassigned and no latch is inferred.
        state_nxt = state;
        count_nxt = count;
        instr_nxt = instr;
        valid_nxt = instr_valid;
        err_nxt   = fetch_err;
        pc_bar    = pc;
        imem_req  = 1'b0;

        case (state)
            S_REQ: begin
                // The state register already reads REQ during reset, so the
                // request is gated to stay low until reset is released and
                // to drop immediately when reset hits mid-fetch.
                imem_req  = !reset;
                count_nxt = count + CW'(1);
                if (imem_ack) begin
                    // An ack in the final allowed cycle still wins.
                    instr_nxt = imem_rdata;
                    valid_nxt = 1'b1;
                    count_nxt = '0;
                    state_nxt = S_EXEC;
                end else if (count >= LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_ERR;
                end
            end

            S_EXEC: begin
                if (!stall) begin
                    if (target[1:0] != 2'b00) begin
                        valid_nxt = 1'b0;
                        err_nxt   = 1'b1;
                        state_nxt = S_ERR;
                    end else begin
                        // PC register loads target on this same edge.
                        pc_bar    = target;
                        valid_nxt = 1'b0;
                        count_nxt = '0;
                        state_nxt = S_REQ;
                    end
                end
            end

            S_ERR: begin
                valid_nxt = 1'b0;
                err_nxt   = 1'b1;
            end

            default: begin
                valid_nxt = 1'b0;
                err_nxt   = 1'b1;
                state_nxt = S_ERR;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl
//   Bench for fetch_ctrl with TIMEOUT=8. The bench models the PC register and
//   the instruction memory. Stimulus tasks push expected fetches and expected
//   pc_bar values into queues; a negedge monitor pops and compares whenever the
//   DUT opens a new execute window or leaves one.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] pc;
    logic [N-1:0] pc_bar;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [31:0]  imem_rdata;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         stall;
    logic         branch_taken;
    logic [N-1:0] branch_target;
    logic         jump;
    logic [N-1:0] jump_target;
    logic         fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
    } fetch_t;

    fetch_t      exp_fetch_q[$];
    logic [31:0] exp_pcbar_q[$];

    fetch_ctrl #(.N(N), .TIMEOUT(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc            (pc),
        .pc_bar        (pc_bar),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .fetch_err     (fetch_err)
    );

    always #5 clk = ~clk;

    // PC register model, reset from the same source.
    always @(posedge clk or posedge reset) begin
        if (reset) pc <= '0;
        else       pc <= pc_bar;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    logic        last_valid = 1'b0;
    logic [31:0] ack_addr   = '0;
    logic [31:0] cur_instr  = '0;

    always @(negedge clk) begin
        if (reset) begin
            last_valid <= 1'b0;
        end else begin
            if (imem_req && imem_ack)
                ack_addr <= imem_addr;
            if (instr_valid && !last_valid) begin
                if (exp_fetch_q.size() == 0) begin
                    check("unexpected_fetch", 32'd1, 32'd0);
                end else begin
                    fetch_t f;
                    f = exp_fetch_q.pop_front();
                    check("instr", instr, f.data);
                    check("fetch_addr", ack_addr, f.addr);
                    cur_instr <= f.data;
                end
            end else if (instr_valid && stall) begin
                check("instr_held", instr, cur_instr);
            end
            if (instr_valid && stall) begin
                check("stall_pc_bar", pc_bar, pc);
                check("stall_req", {31'd0, imem_req}, 32'd0);
            end
            if (instr_valid && !stall) begin
                if (exp_pcbar_q.size() == 0)
                    check("unexpected_exec_exit", 32'd1, 32'd0);
                else
                    check("pc_bar", pc_bar, exp_pcbar_q.pop_front());
            end
            last_valid <= instr_valid;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responds after `waits` idle REQ cycles with `data`.
    task automatic fetch(input int waits, input logic [31:0] addr, input logic [31:0] data);
        fetch_t f;
        int     guard;
        f.data = data;
        f.addr = addr;
        exp_fetch_q.push_back(f);
        guard = 0;
        while (!imem_req && guard < 20) begin
            tick();
            guard++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        repeat (waits) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    // Execute window: `stalls` stalled cycles (with a misaligned jump and a
    // stray ack, both of which must be ignored), then one retiring cycle.
    task automatic exec(input int stalls, input logic j, input logic [31:0] jt,
                        input logic b, input logic [31:0] bt, input logic [31:0] exp_pcbar);
        for (int i = 0; i < stalls; i++) begin
            check("valid_stall", {31'd0, instr_valid}, 32'd1);
            stall       = 1'b1;
            jump        = 1'b1;
            jump_target = 32'h0000_0042;
            imem_ack    = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            tick();
        end
        check("valid_exec", {31'd0, instr_valid}, 32'd1);
        stall         = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
        exp_pcbar_q.push_back(exp_pcbar);
        tick();
        jump         = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        check("rst_pc_bar", pc_bar, 32'd0);
        reset = 1'b0;
        #1;
        check("req_after_release", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        reset         = 1'b1;
        imem_ack      = 1'b0;
        imem_rdata    = '0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;

        apply_reset();

        // Sequential fetch, memory answers in the second REQ cycle.
        fetch(1, 32'h0000_0000, 32'h2010_0005);
        exec(0, 1'b0, '0, 1'b0, '0, 32'h0000_0004);

        // Stalled execute window: four cycles of instr_valid.
        fetch(0, 32'h0000_0004, 32'h8C22_0004);
        exec(3, 1'b0, '0, 1'b0, '0, 32'h0000_0008);

        // Jump has priority over branch.
        fetch(0, 32'h0000_0008, 32'h0000_0013);
        exec(0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0080, 32'h0000_0040);

        // Jump to the top word, then wrap sequentially to zero.
        fetch(3, 32'h0000_0040, 32'h1234_5678);
        exec(0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 32'hFFFF_FFFC);
        fetch(0, 32'hFFFF_FFFC, 32'hCAFE_F00D);
        exec(0, 1'b0, '0, 1'b0, '0, 32'h0000_0000);

        // Aligned branch after a stall.
        fetch(2, 32'h0000_0000, 32'h0BAD_C0DE);
        exec(1, 1'b0, '0, 1'b1, 32'h0000_0080, 32'h0000_0080);

        // Misaligned branch target: error, PC held.
        fetch(0, 32'h0000_0080, 32'h55AA_55AA);
        exec(0, 1'b0, '0, 1'b1, 32'h0000_0042, 32'h0000_0080);
        check("misalign_err", {31'd0, fetch_err}, 32'd1);
        check("misalign_req", {31'd0, imem_req}, 32'd0);
        check("misalign_valid", {31'd0, instr_valid}, 32'd0);
        check("misalign_pc_bar", pc_bar, 32'h0000_0080);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        tick();
        check("err_sticky", {31'd0, fetch_err}, 32'd1);
        check("err_req", {31'd0, imem_req}, 32'd0);
        check("err_valid", {31'd0, instr_valid}, 32'd0);
        check("err_pc", pc, 32'h0000_0080);

        // Timeout: eight REQ cycles without ack.
        apply_reset();
        repeat (7) tick();
        check("to_req_8th", {31'd0, imem_req}, 32'd1);
        check("to_err_8th", {31'd0, fetch_err}, 32'd0);
        tick();
        check("to_err", {31'd0, fetch_err}, 32'd1);
        check("to_req", {31'd0, imem_req}, 32'd0);
        check("to_pc_bar", pc_bar, pc);

        // Ack in the eighth REQ cycle wins over the timeout.
        apply_reset();
        fetch(7, 32'h0000_0000, 32'h1111_1111);
        check("late_ack_err", {31'd0, fetch_err}, 32'd0);
        exec(0, 1'b0, '0, 1'b0, '0, 32'h0000_0004);

        // Reset mid-REQ drops the request immediately.
        tick();
        check("midreq_req_before", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreq_req_drop", {31'd0, imem_req}, 32'd0);
        check("midreq_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        check("fetch_q_empty", exp_fetch_q.size(), 32'd0);
        check("pcbar_q_empty", exp_pcbar_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
